alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Execute-stage controller that sits directly upstream of the 8-bit add/subtract `alu` and consumes its result. It holds a 4-entry 8-bit register file and accepts one instruction at a time over a valid/ready handshake. It drives the ALU operands and `op`, then captures the 9-bit result and the carry/overflow flags. It writes the result back to the register file and updates a flag register (C, O, Z).

## Interface
Parameters:
- `NREGS`, 4: register-file depth; fixed at 4, with 2-bit addresses.
- `W`, 8: data width; matches ALU operand width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `instr_opc`  in  2  opcode: 00 LDI, 01 ADD, 10 SUB, 11 MOV.
- `instr_rd`  in  2  destination register.
- `instr_rs1`  in  2  source 1.
- `instr_rs2`  in  2  source 2.
- `instr_imm`  in  8  immediate, used by LDI only.
- `alu_a`  out  8  ALU operand a (registered).
- `alu_b`  out  8  ALU operand b (registered).
- `alu_op`  out  1  1 = add, 0 = subtract (registered).
- `alu_out`  in  9  ALU result; bit 8 is carry/borrow.
- `alu_flag_c`  in  1  ALU carry flag.
- `alu_flag_o`  in  1  ALU overflow flag.
- `done`  out  1  one-cycle pulse in the WB cycle.
- `result`  out  8  value being written back; valid while `done` = 1.
- `flags`  out  3  {C, O, Z} flag register.
- `dbg_addr`  in  2  register-file read address for debug/verification.
- `dbg_data`  out  8  combinational read `rf[dbg_addr]`.

## Operation
- FSM states: IDLE, EXEC, WB. Transitions:
  - IDLE → EXEC on `instr_valid & instr_ready`.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- `instr_ready` = (state == IDLE). It is combinational from the state register.
- On accept, the following registers latch the instruction fields and operands:
  - ADD: `alu_a` ← rf[rs1], `alu_b` ← rf[rs2], `alu_op` ← 1.
  - SUB: `alu_a` ← rf[rs1], `alu_b` ← rf[rs2], `alu_op` ← 0.
  - LDI: `alu_a` ← imm, `alu_b` ← 0, `alu_op` ← 1.
  - MOV: `alu_a` ← rf[rs1], `alu_b` ← 0, `alu_op` ← 1.
  - In all cases the opcode and rd are also latched.
- End of EXEC: `result_q` ← `alu_out[7:0]` (bit 8 is discarded), `c_q` ← `alu_flag_c`, `o_q` ← `alu_flag_o`.
- WB cycle:
  - `done` = 1 and `result` = `result_q`.
  - At the closing edge, rf[rd] ← `result_q`.
  - ADD/SUB only: flags ← {c_q, o_q, result_q == 0}.
  - LDI/MOV: flags are unchanged.
- Flags are captured verbatim from the ALU; the controller never recomputes C or O.
- rd == rs1 or rd == rs2 is legal. Operands are read at accept, before any write.
- Because instructions are serialised, a write in WB is visible to the next accepted instruction. The next accept occurs no earlier than the cycle after WB, so no hazard logic is needed.
- Register r0 is an ordinary register, not hardwired to zero.

## Timing
- Reset (async, `rst_n` low): state → IDLE; rf all 0; `alu_a` = `alu_b` = 0; `alu_op` = 0; `result_q` = 0; flags = 000; `done` = 0. `instr_ready` reads 1 while in reset.
- Latency, with accept at edge N:
  - EXEC occupies cycle N..N+1; `result_q` captured at edge N+1.
  - WB occupies cycle N+1..N+2; `done` is high in that cycle.
  - rf and flags are updated at edge N+2.
- Throughput: one instruction per 3 cycles. With `instr_valid` held high, accepts occur at edges N, N+3, N+6.
- While the controller is not ready, `instr_valid` is ignored and instruction fields are don't-care.
- The ALU is combinational. `alu_out` must settle within the EXEC cycle.
- Reset asserted in EXEC or WB: the instruction is aborted, there is no writeback, and all state returns to reset values immediately.
- `dbg_data` reflects a write from the edge after WB onward.

## Test plan
- Reset then LDI r0 = 40, LDI r1 = 20 → `dbg_data` shows r0 = 0x28, r1 = 0x14; flags stay 000; each `done` occurs 2 cycles after accept.
- ADD r2 = r0 + r1 → `alu_a` = 40, `alu_b` = 20, `alu_op` = 1 in EXEC; `result` = 60 with `done`; r2 = 60; flags C = 0, O = 0, Z = 0. Then SUB r3 = r0 − r1 → `alu_op` = 0, r3 = 20, Z = 0.
- LDI r0 = 0xFF, LDI r1 = 0x01, ADD r2 = r0 + r1 → r2 = 0x00, C = 1 (from ALU), Z = 1. Then MOV r3 = r2 → r3 = 0x00, flags unchanged.
- LDI 0x7F and 0x01, ADD → 0x80, O = 1. LDI 0x80 and 0x01, SUB → 0x7F, O = 1.
- Hold `instr_valid` high with 4 queued instructions → `instr_ready` pattern 1,0,0 repeating; accepts exactly every 3 cycles; no instruction lost or duplicated.
- Assert `rst_n` low mid-EXEC of ADD r2 → r2 remains 0, `done` never pulses, flags = 000, `instr_ready` = 1 after release.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
//   Execute-stage controller for an external combinational 8-bit add/subtract
//   ALU. Accepts one instruction at a time (valid/ready), registers the ALU
//   operands, captures the ALU result and flags, then writes the result back
//   into a 4-entry register file and updates the {C, O, Z} flag register.
//   One instruction takes three cycles: IDLE (accept) -> EXEC -> WB.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instr_opc             00 LDI, 01 ADD, 10 SUB, 11 MOV
//   instr_rd/rs1/rs2      destination and source register addresses
//   instr_imm             immediate for LDI
//   alu_a, alu_b, alu_op  registered ALU operands / op (1 = add, 0 = sub)
//   alu_out, alu_flag_c/o ALU result (bit 8 unused here) and flags
//   done, result          write-back pulse and the value being written
//   flags                 {C, O, Z}
//   dbg_addr, dbg_data    combinational register-file read port

module alu_exec_ctrl #(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [1:0]   instr_opc,
  input  logic [1:0]   instr_rd,
  input  logic [1:0]   instr_rs1,
  input  logic [1:0]   instr_rs2,
  input  logic [W-1:0] instr_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_op,
  input  logic [W:0]   alu_out,
  input  logic         alu_flag_c,
  input  logic         alu_flag_o,
  output logic         done,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  localparam logic [1:0] OPC_LDI = 2'b00;
  localparam logic [1:0] OPC_ADD = 2'b01;
  localparam logic [1:0] OPC_SUB = 2'b10;
  localparam logic [1:0] OPC_MOV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     opc_reg, rd_reg;
  logic [W-1:0]   a_reg, b_reg, a_next, b_next;
  logic           op_reg, op_next;
  logic [W-1:0]   result_reg;
  logic           c_reg, o_reg;
  logic [2:0]     flags_reg;
  logic [W-1:0]   rf_reg [NREGS];
  logic           accept;
  logic           wb_arith;

  // The carry/borrow is taken from alu_flag_c, so alu_out[8] is not used.
  logic           unused_alu_msb;
  assign unused_alu_msb = alu_out[W];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = S_EXEC;
      end
      S_EXEC: state_next = S_WB;
      S_WB: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept   = instr_valid & instr_ready;
  assign wb_arith = (state_reg == S_WB) && ((opc_reg == OPC_ADD) || (opc_reg == OPC_SUB));

  // ------------------------------------------------------ operand select
  // Operands are read from the register file at accept time; a pending
  // write-back can never collide because accepts only happen in IDLE.
  always_comb begin
    a_next  = rf_reg[instr_rs1];
    b_next  = rf_reg[instr_rs2];
    op_next = 1'b1;
    case (instr_opc)
      OPC_LDI: begin
        a_next = instr_imm;
        b_next = '0;
      end
      OPC_SUB: op_next = 1'b0;
      OPC_MOV: b_next = '0;
      default: ;
    endcase
  end

  // ------------------------------------------------------ datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 1'b0;
      opc_reg    <= OPC_LDI;
      rd_reg     <= '0;
      result_reg <= '0;
      c_reg      <= 1'b0;
      o_reg      <= 1'b0;
      flags_reg  <= '0;
    end else begin
      if (accept) begin
        a_reg   <= a_next;
        b_reg   <= b_next;
        op_reg  <= op_next;
        opc_reg <= instr_opc;
        rd_reg  <= instr_rd;
      end
      if (state_reg == S_EXEC) begin
        result_reg <= alu_out[W-1:0];
        c_reg      <= alu_flag_c;
        o_reg      <= alu_flag_o;
      end
      // LDI/MOV leave the flags untouched.
      if (wb_arith) flags_reg <= {c_reg, o_reg, (result_reg == '0)};
    end
  end

  // ------------------------------------------------------- register file
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf
      localparam logic [1:0] IDX = 2'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   rf_reg[gi] <= '0;
        else if ((state_reg == S_WB) && (rd_reg == IDX)) rf_reg[gi] <= result_reg;
      end
    end
  endgenerate

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_op   = op_reg;
  assign result   = result_reg;
  assign flags    = flags_reg;
  assign dbg_data = rf_reg[dbg_addr];

endmodule
